axis_linear_upsampler: RTL and testbench



---
 rtl/axis_dac_pkg.sv | 17 +
 rtl/upsampler_ramp_acc.sv | 51 +++++
 rtl/axis_linear_upsampler.sv | 130 +++++++++++++
 tb/tb_axis_linear_upsampler.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_dac_pkg.sv
// axis_dac_pkg: shared state type, sizing helper and limits for the DAC feed path.
package axis_dac_pkg;

    localparam int MAX_LOG2_RATIO = 8;

    typedef enum logic [1:0] {
        IDLE,
        PRIME,
        RUN
    } upsampler_state_t;

    // Accumulator carries value*R plus one bit so that acc+step stays exact mid-segment.
    function automatic int acc_width(input int width, input int log2_ratio);
        return width + log2_ratio + 1;
    endfunction

endpackage

// File: rtl/upsampler_ramp_acc.sv
// upsampler_ramp_acc: scaled-value accumulator, per-segment step and phase counter.
// Load rescales a base sample by R, step load restarts the phase, advance moves one output along.
module upsampler_ramp_acc
    import axis_dac_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int LOG2_RATIO = 4
) (
    input  logic                    aclk,
    input  logic                    arst_n,
    input  logic                    acc_load,
    input  logic signed [WIDTH-1:0] acc_base,
    input  logic                    step_load,
    input  logic signed [WIDTH:0]   step_value,
    input  logic                    advance,
    output logic [LOG2_RATIO-1:0]   phase,
    output logic signed [WIDTH-1:0] data
);

    localparam int ACC_W = acc_width(WIDTH, LOG2_RATIO);

    logic signed [ACC_W-1:0] acc;
    logic signed [WIDTH:0]   step;
    logic signed [ACC_W-1:0] base_scaled;

    assign base_scaled = ACC_W'(acc_base) <<< LOG2_RATIO;

    // A load takes priority over advance so each segment restarts exactly on x_cur*R.
    always_ff @(posedge aclk) begin
        if (!arst_n) begin
            acc   <= '0;
            step  <= '0;
            phase <= '0;
        end else begin
            if (acc_load) begin
                acc <= base_scaled;
            end else if (advance) begin
                acc <= acc + ACC_W'(step);
            end
            if (step_load) begin
                step  <= step_value;
                phase <= '0;
            end else if (advance) begin
                phase <= phase + LOG2_RATIO'(1);
            end
        end
    end

    assign data = acc[LOG2_RATIO +: WIDTH];

endmodule

// File: rtl/axis_linear_upsampler.sv
// axis_linear_upsampler: AXI-Stream R=2**LOG2_RATIO upsampler feeding the delta-sigma DAC.
// Define AXIS_UPSAMPLER_LINEAR_EN for linear interpolation; otherwise a zero-order hold is built.
module axis_linear_upsampler
    import axis_dac_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int LOG2_RATIO = 4
) (
    input  logic                    aclk,
    input  logic                    arst_n,
    input  logic signed [WIDTH-1:0] s_axis_tdata,
    input  logic                    s_axis_tvalid,
    output logic                    s_axis_tready,
    output logic signed [WIDTH-1:0] m_axis_tdata,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
    output logic                    underrun
);

    localparam logic [LOG2_RATIO-1:0] LAST_PHASE = '1;

    if (LOG2_RATIO < 1 || LOG2_RATIO > MAX_LOG2_RATIO) begin : g_bad_ratio
        $error("axis_linear_upsampler: LOG2_RATIO out of range");
    end

    upsampler_state_t        state;
    logic signed [WIDTH-1:0] x_cur;
    logic [LOG2_RATIO-1:0]   phase;
    logic                    s_hs;
    logic                    xfer;
    logic                    seg_end;
    logic                    acc_load;
    logic                    step_load;
    logic signed [WIDTH-1:0] acc_base;
    logic signed [WIDTH:0]   step_value;

    assign s_hs    = s_axis_tvalid && s_axis_tready;
    assign xfer    = m_axis_tvalid && m_axis_tready;
    assign seg_end = xfer && (phase == LAST_PHASE);

    always_comb begin
        s_axis_tready = 1'b0;
        if (arst_n) begin
            case (state)
                IDLE, PRIME: s_axis_tready = 1'b1;
                RUN:         s_axis_tready = (phase == LAST_PHASE) && m_axis_tready;
                default:     s_axis_tready = 1'b0;
            endcase
        end
    end

    // Every segment restarts from x_cur*R; a missing sample leaves step at zero so the output holds flat.
    always_comb begin
        acc_load = ((state == IDLE) && s_hs) || seg_end;
        acc_base = (state == IDLE) ? s_axis_tdata : x_cur;
`ifdef AXIS_UPSAMPLER_LINEAR_EN
        step_load  = ((state == PRIME) && s_hs) || seg_end;
        step_value = (seg_end && !s_axis_tvalid) ? '0
                   : (WIDTH+1)'(s_axis_tdata) - (WIDTH+1)'(x_cur);
`else
        step_load  = seg_end;
        step_value = '0;
        if (seg_end && s_axis_tvalid) begin
            acc_base = s_axis_tdata;
        end
`endif
    end

    always_ff @(posedge aclk) begin
        if (!arst_n) begin
            state         <= IDLE;
            x_cur         <= '0;
            m_axis_tvalid <= 1'b0;
            underrun      <= 1'b0;
        end else begin
            underrun <= 1'b0;
            case (state)
                IDLE: begin
                    if (s_hs) begin
                        x_cur <= s_axis_tdata;
`ifdef AXIS_UPSAMPLER_LINEAR_EN
                        state <= PRIME;
`else
                        state         <= RUN;
                        m_axis_tvalid <= 1'b1;
`endif
                    end
                end
`ifdef AXIS_UPSAMPLER_LINEAR_EN
                PRIME: begin
                    if (s_hs) begin
                        x_cur         <= s_axis_tdata;
                        state         <= RUN;
                        m_axis_tvalid <= 1'b1;
                    end
                end
`endif
                RUN: begin
                    if (seg_end) begin
                        if (s_axis_tvalid) begin
                            x_cur <= s_axis_tdata;
                        end else begin
                            underrun <= 1'b1;
                        end
                    end
                end
                default: begin
                    state         <= IDLE;
                    m_axis_tvalid <= 1'b0;
                end
            endcase
        end
    end

    upsampler_ramp_acc #(
        .WIDTH      (WIDTH),
        .LOG2_RATIO (LOG2_RATIO)
    ) u_ramp_acc (
        .aclk       (aclk),
        .arst_n     (arst_n),
        .acc_load   (acc_load),
        .acc_base   (acc_base),
        .step_load  (step_load),
        .step_value (step_value),
        .advance    (xfer),
        .phase      (phase),
        .data       (m_axis_tdata)
    );

endmodule

// File: tb/tb_axis_linear_upsampler.sv
// tb_axis_linear_upsampler: directed scoreboard bench, WIDTH=16, R=4.
// Expected tables follow AXIS_UPSAMPLER_LINEAR_EN (linear) or its absence (zero-order hold).
module tb_axis_linear_upsampler;

    localparam int WIDTH      = 16;
    localparam int LOG2_RATIO = 2;
    localparam int R          = 4;

    logic                    aclk = 1'b0;
    logic                    arst_n;
    logic signed [WIDTH-1:0] s_axis_tdata;
    logic                    s_axis_tvalid;
    logic                    s_axis_tready;
    logic signed [WIDTH-1:0] m_axis_tdata;
    logic                    m_axis_tvalid;
    logic                    m_axis_tready;
    logic                    underrun;

    typedef struct {
        logic signed [WIDTH-1:0] data;
        bit                      uflag;
        bit                      ucheck;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   vectors     = 0;
    int   miscompares = 0;
    int   out_idx     = 0;
    bit   bp_en       = 1'b0;

    axis_linear_upsampler #(
        .WIDTH      (WIDTH),
        .LOG2_RATIO (LOG2_RATIO)
    ) dut (
        .aclk          (aclk),
        .arst_n        (arst_n),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .underrun      (underrun)
    );

    always #5 aclk = ~aclk;

    task automatic check_output(input string name, input logic signed [31:0] actual,
                                input logic signed [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic report_timeout(input string name);
        vectors++;
        miscompares++;
        $display("[TB] FAIL %s: timed out, got no event, expected one", name);
    endtask

    task automatic expect_out(input int d, input bit uf = 1'b0, input bit uc = 1'b1);
        exp_t x;
        x.data   = WIDTH'(d);
        x.uflag  = uf;
        x.ucheck = uc;
        exp_q.push_back(x);
    endtask

    // Present one sample and hold it until the DUT takes it.
    task automatic apply_stimulus(input int value);
        bit hs = 1'b0;
        int n  = 0;
        s_axis_tdata  = WIDTH'(value);
        s_axis_tvalid = 1'b1;
        while (!hs && n < 300) begin
            @(negedge aclk);
            hs = s_axis_tvalid && s_axis_tready;
            @(posedge aclk);
            #1;
            n++;
        end
        s_axis_tvalid = 1'b0;
        if (!hs) report_timeout("sample_accept");
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() > 0 && n < 400) begin
            @(posedge aclk);
            #1;
            n++;
        end
        if (exp_q.size() > 0) report_timeout("output_drain");
    endtask

    task automatic wait_underrun();
        bit seen = 1'b0;
        int n    = 0;
        while (!seen && n < 100) begin
            @(negedge aclk);
            seen = underrun;
            n++;
        end
        @(posedge aclk);
        #1;
        if (!seen) report_timeout("underrun_wait");
    endtask

    task automatic do_reset();
        arst_n        = 1'b0;
        s_axis_tvalid = 1'b0;
        repeat (2) @(posedge aclk);
        #1;
        arst_n  = 1'b1;
        out_idx = 0;
        exp_q.delete();
    endtask

    always @(posedge aclk) begin
        #1;
        m_axis_tready = bp_en ? ($urandom_range(0, 2) != 0) : 1'b1;
    end

    // Monitor: pop and compare on each output transfer, and police the input handshake.
    always @(negedge aclk) begin
        if (arst_n) begin
            if (s_axis_tvalid && s_axis_tready && m_axis_tvalid)
                check_output("in_phase", 32'(m_axis_tready && (out_idx % R == R - 1)), 1);
            if (m_axis_tvalid && !m_axis_tready)
                check_output("stall_ready", 32'(s_axis_tready), 0);
            if (m_axis_tvalid && m_axis_tready) begin
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check_output($sformatf("data[%0d]", out_idx), m_axis_tdata, e.data);
                    if (e.ucheck)
                        check_output($sformatf("underrun[%0d]", out_idx), 32'(underrun), 32'(e.uflag));
                end
                out_idx++;
            end
        end
    end

    task automatic push_ramp();
`ifdef AXIS_UPSAMPLER_LINEAR_EN
        expect_out(0); expect_out(100); expect_out(200); expect_out(300);
`else
        expect_out(0); expect_out(0); expect_out(0); expect_out(0);
`endif
        expect_out(400); expect_out(400); expect_out(400); expect_out(400);
    endtask

    initial begin
        arst_n        = 1'b0;
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = 16'sd123;
        m_axis_tready = 1'b1;
        repeat (2) @(posedge aclk);
        @(negedge aclk);
        check_output("rst_m_valid", 32'(m_axis_tvalid), 0);
        check_output("rst_m_data", m_axis_tdata, 0);
        check_output("rst_s_ready", 32'(s_axis_tready), 0);
        check_output("rst_underrun", 32'(underrun), 0);
        s_axis_tvalid = 1'b0;
        @(posedge aclk);
        #1;
        arst_n = 1'b1;
        @(negedge aclk);
        check_output("idle_s_ready", 32'(s_axis_tready), 1);
        check_output("idle_m_valid", 32'(m_axis_tvalid), 0);

        $display("[TB] ramp up");
        do_reset();
        push_ramp();
        apply_stimulus(0); apply_stimulus(400); apply_stimulus(400);
        wait_drain();

        $display("[TB] negative floor");
        do_reset();
`ifdef AXIS_UPSAMPLER_LINEAR_EN
        expect_out(0); expect_out(-1); expect_out(-2); expect_out(-3);
`else
        expect_out(0); expect_out(0); expect_out(0); expect_out(0);
        expect_out(-3); expect_out(-3); expect_out(-3); expect_out(-3);
`endif
        apply_stimulus(0); apply_stimulus(-3);
        wait_drain();
        do_reset();
        expect_out(0); expect_out(0); expect_out(0); expect_out(0);
`ifdef AXIS_UPSAMPLER_LINEAR_EN
        expect_out(1, 1'b1);
`else
        expect_out(1); expect_out(1); expect_out(1); expect_out(1);
`endif
        apply_stimulus(0); apply_stimulus(1);
        wait_drain();

        $display("[TB] extremes");
        do_reset();
`ifdef AXIS_UPSAMPLER_LINEAR_EN
        expect_out(-32768); expect_out(-16385); expect_out(-1); expect_out(16383);
        expect_out(32767, 1'b1);
`else
        expect_out(-32768); expect_out(-32768); expect_out(-32768); expect_out(-32768);
        expect_out(32767); expect_out(32767); expect_out(32767); expect_out(32767);
`endif
        apply_stimulus(-32768); apply_stimulus(32767);
        wait_drain();

        $display("[TB] underrun");
        do_reset();
`ifdef AXIS_UPSAMPLER_LINEAR_EN
        expect_out(0); expect_out(10); expect_out(20); expect_out(30);
        expect_out(40, 1'b1); expect_out(40); expect_out(40); expect_out(40);
        expect_out(40); expect_out(50); expect_out(60); expect_out(70);
`else
        expect_out(0); expect_out(0); expect_out(0); expect_out(0);
        expect_out(40); expect_out(40); expect_out(40); expect_out(40);
        expect_out(40, 1'b1); expect_out(40); expect_out(40); expect_out(40);
        expect_out(80); expect_out(80); expect_out(80); expect_out(80);
`endif
        apply_stimulus(0); apply_stimulus(40);
        wait_underrun();
        apply_stimulus(80);
        wait_drain();

        $display("[TB] backpressure");
        do_reset();
        bp_en = 1'b1;
        push_ramp();
        apply_stimulus(0); apply_stimulus(400); apply_stimulus(400);
        wait_drain();
        bp_en = 1'b0;

        $display("[TB] reset mid-segment");
        do_reset();
`ifdef AXIS_UPSAMPLER_LINEAR_EN
        expect_out(0); expect_out(100);
`else
        expect_out(0); expect_out(0);
`endif
        apply_stimulus(0); apply_stimulus(400);
        wait_drain();
        arst_n = 1'b0;
        @(posedge aclk);
        @(negedge aclk);
        check_output("midrst_m_valid", 32'(m_axis_tvalid), 0);
        check_output("midrst_m_data", m_axis_tdata, 0);
        @(posedge aclk);
        #1;
        arst_n  = 1'b1;
        out_idx = 0;
        exp_q.delete();
        @(negedge aclk);
        check_output("midrst_idle_ready", 32'(s_axis_tready), 1);
        @(posedge aclk);
        #1;
`ifdef AXIS_UPSAMPLER_LINEAR_EN
        expect_out(8); expect_out(10); expect_out(12); expect_out(14);
`else
        expect_out(8); expect_out(8); expect_out(8); expect_out(8);
        expect_out(16); expect_out(16); expect_out(16); expect_out(16);
`endif
        apply_stimulus(8); apply_stimulus(16);
        wait_drain();

        do_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got no finish, expected finish before 500000");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
